icache_fill_ctrl: RTL

//  Miss/refill sequencer for the direct-mapped instruction cache. On a cache miss it stalls fetch,

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_line_buf.sv | 26 ++
 rtl/icache_fill_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared i-cache refill types and constants: line geometry, legal instruction window, fill FSM states.
// Pure declarations, no timing; backpressure is handled by the users of these types.
package icache_pkg;

  localparam int LINE_WORDS = 16;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam int OFS_W      = $clog2(LINE_BYTES);
  localparam int BEAT_W     = $clog2(LINE_WORDS);

  localparam logic [31:0] IMEM_BASE  = 32'h0001_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0001_01FF;

  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, ERR} fill_state_t;

  typedef logic [32*LINE_WORDS-1:0] line_t;

  function automatic logic [31:0] line_base(input logic [31:0] pc);
    return {pc[31:OFS_W], {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Beat-indexed line assembly buffer: one 32-bit word written per beat, whole line readable every cycle.
// Write visible one cycle after i_we; no backpressure, every strobed beat is stored.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [BEAT_W-1:0] i_idx,
  input  logic [31:0]       i_dat,
  output line_t             o_line
);

  line_t r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_we) begin
      r_line[32*i_idx +: 32] <= i_dat;
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss/refill sequencer: miss -> mem_req next cycle, fill_we one cycle after the last beat.
// Holds mem_req until mem_gnt; fetch is stalled for the whole fill; out-of-range misses lock in ERR.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_miss,
  input  logic [31:0]      i_miss_pc,
  input  logic             i_flush,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr,
  input  logic             i_mem_gnt,
  input  logic             i_mem_rvalid,
  input  logic [31:0]      i_mem_rdata,
  output logic             o_fill_we,
  output logic [31:0]      o_fill_addr,
  output line_t            o_fill_line,
  output logic             o_stall,
  output logic             o_fill_err,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [BEAT_W-1:0] BEAT_ONE = 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

  fill_state_t       r_state;
  fill_state_t       w_next;
  logic [31:0]       r_base;
  logic [BEAT_W-1:0] r_cnt;
  logic              r_drop;
  logic              r_err;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              w_in_rng;
  logic              w_beat_we;

  assign w_in_rng  = (i_miss_pc >= IMEM_BASE) && (i_miss_pc <= IMEM_LIMIT);
  assign w_beat_we = (r_state == RECV) && i_mem_rvalid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_miss) w_next = w_in_rng ? REQ : ERR;
      REQ:     if (i_mem_gnt) w_next = RECV;
               else if (i_flush) w_next = IDLE;
      RECV:    if (w_beat_we && (r_cnt == BEAT_LAST)) w_next = WRITE;
      WRITE:   w_next = IDLE;
      ERR:     w_next = ERR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_err      <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_miss && w_in_rng) begin
            r_base <= line_base(i_miss_pc);
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_ONE;
          end else if (i_miss) begin
            r_err <= 1'b1;
          end
        end
        REQ: begin
          // A granted request must still be drained even if flushed in the same cycle.
          if (i_mem_gnt) begin
            r_cnt  <= '0;
            r_drop <= i_flush;
          end
        end
        RECV: begin
          if (w_beat_we) r_cnt <= r_cnt + BEAT_ONE;
          if (i_flush) r_drop <= 1'b1;
        end
        WRITE:   r_drop <= 1'b0;
        default: ;
      endcase
    end
  end

  icache_line_buf u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_beat_we),
    .i_idx  (r_cnt),
    .i_dat  (i_mem_rdata),
    .o_line (o_fill_line)
  );

  assign o_mem_req   = (r_state == REQ);
  assign o_mem_addr  = r_base;
  assign o_fill_we   = (r_state == WRITE) && !r_drop;
  assign o_fill_addr = r_base;
  assign o_stall     = (r_state != IDLE) || i_miss;
  assign o_fill_err  = r_err;
  assign o_miss_cnt  = r_miss_cnt;

endmodule
